tnn_feature_packer: RTL and testbench



---
 rtl/tnn_feature_packer.sv | 116 +++++++++++
 tb/tb_tnn_feature_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_packer.sv
// Quantises raw samples against seven programmable thresholds and packs five
// 3-bit codes per framed vector into a registered valid/ready output.
module tnn_feature_packer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              thr_we,
  input  logic [2:0]        thr_addr,
  input  logic [DATA_W-1:0] thr_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2:0]        m_a,
  output logic [2:0]        m_b,
  output logic [2:0]        m_c,
  output logic [2:0]        m_d,
  output logic [2:0]        m_e,
  output logic              err_len,
  output logic [CNT_W-1:0]  vec_cnt
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t     state_reg;
  logic [2:0] idx_reg;
  logic [2:0] slot_reg [4];
  logic [6:0] hit;
  logic [2:0] code;
  logic       accept;

  // Each threshold is compared in parallel; the code is the count of hits,
  // so the threshold set does not need to be monotonic.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_thr
      logic [DATA_W-1:0] thr_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          thr_reg <= DATA_W'((gi + 1) << (DATA_W - 3));
        else if (thr_we && thr_addr == 3'(gi))
          thr_reg <= thr_data;
      end
      assign hit[gi] = (s_data >= thr_reg);
    end
  endgenerate

  always_comb begin
    code = 3'd0;
    for (int k = 0; k < 7; k++)
      code = code + 3'(hit[k]);
  end

  // Only the fifth sample needs room in the output register.
  assign s_ready = (state_reg == DRAIN) || (idx_reg != 3'd4) || !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      idx_reg   <= 3'd0;
      for (int k = 0; k < 4; k++)
        slot_reg[k] <= 3'd0;
      m_valid   <= 1'b0;
      m_a       <= 3'd0;
      m_b       <= 3'd0;
      m_c       <= 3'd0;
      m_d       <= 3'd0;
      m_e       <= 3'd0;
      err_len   <= 1'b0;
      vec_cnt   <= '0;
    end else begin
      err_len <= 1'b0;
      if (m_valid && m_ready)
        m_valid <= 1'b0;
      if (accept) begin
        case (state_reg)
          FILL: begin
            if (idx_reg == 3'd4) begin
              m_a     <= slot_reg[0];
              m_b     <= slot_reg[1];
              m_c     <= slot_reg[2];
              m_d     <= slot_reg[3];
              m_e     <= code;
              m_valid <= 1'b1;
              vec_cnt <= vec_cnt + CNT_W'(1);
              idx_reg <= 3'd0;
              if (!s_last) begin
                state_reg <= DRAIN;
                err_len   <= 1'b1;
              end
            end else if (s_last) begin
              idx_reg <= 3'd0;
              err_len <= 1'b1;
            end else begin
              slot_reg[idx_reg[1:0]] <= code;
              idx_reg                <= idx_reg + 3'd1;
            end
          end
          DRAIN: begin
            if (s_last) begin
              state_reg <= FILL;
              idx_reg   <= 3'd0;
            end
          end
          default: state_reg <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed bench for tnn_feature_packer: quantisation, framing errors,
// back-pressure and asynchronous reset behaviour.
module tb_tnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        thr_we = 1'b0;
  logic [2:0]  thr_addr = 3'd0;
  logic [7:0]  thr_data = 8'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [2:0]  m_a, m_b, m_c, m_d, m_e;
  logic        err_len;
  logic [15:0] vec_cnt;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int exp_cnt = 0;
  logic [14:0] got_q[$];

  tnn_feature_packer #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .thr_we(thr_we), .thr_addr(thr_addr),
    .thr_data(thr_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d), .m_e(m_e),
    .err_len(err_len), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  // Record every handshaken vector and every cycle err_len is high.
  always @(posedge clk) begin
    if (rst_n && m_valid && m_ready)
      got_q.push_back({m_a, m_b, m_c, m_d, m_e});
    if (rst_n && err_len)
      err_seen++;
  end

  function automatic logic [14:0] pack(input int a, b, c, d, e);
    return {3'(a), 3'(b), 3'(c), 3'(d), 3'(e)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input string tag, input logic [14:0] exp);
    if (got_q.size() == 0) begin
      check({tag, "_missing"}, 32'(0), 32'(1));
    end else begin
      check(tag, 32'(got_q.pop_front()), 32'(exp));
    end
  endtask

  task automatic write_thr(input logic [2:0] a, input logic [7:0] v);
    @(negedge clk);
    thr_we   = 1'b1;
    thr_addr = a;
    thr_data = v;
    @(negedge clk);
    thr_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'(1));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_codes", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(0));
    check("rst_vec_cnt", 32'(vec_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vector with default thresholds.
    send(8'h10, 1'b0); send(8'h45, 1'b0); send(8'h80, 1'b0); send(8'hC3, 1'b0);
    send(8'hFF, 1'b1);
    check("basic_m_valid", 32'(m_valid), 32'(1));
    check("basic_codes", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(pack(0, 2, 4, 6, 7)));
    exp_cnt++;
    check("basic_vec_cnt", 32'(vec_cnt), 32'(exp_cnt));
    idle(2);
    expect_vec("basic_hs", pack(0, 2, 4, 6, 7));
    check("basic_m_valid_clr", 32'(m_valid), 32'(0));
    check("basic_no_err", 32'(err_seen), 32'(0));

    // Threshold boundaries.
    send(8'h1F, 1'b0); send(8'h20, 1'b0); send(8'hDF, 1'b0); send(8'hE0, 1'b0);
    send(8'h00, 1'b1);
    exp_cnt++;
    idle(2);
    expect_vec("boundary", pack(0, 1, 6, 7, 0));

    // Back-pressure: two vectors queued while the neuron stalls.
    @(negedge clk);
    m_ready = 1'b0;
    send(8'h00, 1'b0); send(8'h20, 1'b0); send(8'h40, 1'b0); send(8'h60, 1'b0);
    send(8'h80, 1'b1);
    exp_cnt++;
    send(8'hA0, 1'b0); send(8'hC0, 1'b0); send(8'hE0, 1'b0); send(8'h10, 1'b0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h30;
    s_last  = 1'b1;
    #1;
    check("bp_s_ready_low", 32'(s_ready), 32'(0));
    check("bp_hold_a", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(pack(0, 1, 2, 3, 4)));
    repeat (3) @(negedge clk);
    #1;
    check("bp_hold_a_later", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(pack(0, 1, 2, 3, 4)));
    check("bp_no_hs_yet", 32'(got_q.size()), 32'(0));
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    check("bp_s_ready_high", 32'(s_ready), 32'(1));
    @(posedge clk);
    #1;
    exp_cnt++;
    check("bp_b_loaded", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(pack(5, 6, 7, 0, 1)));
    check("bp_m_valid_kept", 32'(m_valid), 32'(1));
    idle(2);
    expect_vec("bp_first", pack(0, 1, 2, 3, 4));
    expect_vec("bp_second", pack(5, 6, 7, 0, 1));
    check("bp_no_dup", 32'(got_q.size()), 32'(0));
    check("bp_vec_cnt", 32'(vec_cnt), 32'(exp_cnt));

    // Short frame then a good vector.
    send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    check("short_err_pulse", 32'(err_len), 32'(1));
    send(8'h20, 1'b0);
    check("short_err_one_cycle", 32'(err_len), 32'(0));
    send(8'h40, 1'b0); send(8'h60, 1'b0); send(8'h80, 1'b0); send(8'hA0, 1'b1);
    exp_cnt++;
    idle(2);
    expect_vec("short_next", pack(1, 2, 3, 4, 5));
    check("short_only_one", 32'(got_q.size()), 32'(0));
    check("short_err_count", 32'(err_seen), 32'(1));

    // Long frame: seven samples, last on the seventh.
    send(8'hE0, 1'b0); send(8'hC0, 1'b0); send(8'hA0, 1'b0); send(8'h80, 1'b0);
    send(8'h60, 1'b0);
    exp_cnt++;
    check("long_err_pulse", 32'(err_len), 32'(1));
    send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h20, 1'b0); send(8'h20, 1'b0);
    send(8'hFF, 1'b1);
    exp_cnt++;
    idle(2);
    expect_vec("long_first", pack(7, 6, 5, 4, 3));
    expect_vec("long_next", pack(0, 0, 1, 1, 7));
    check("long_err_count", 32'(err_seen), 32'(2));
    check("long_vec_cnt", 32'(vec_cnt), 32'(exp_cnt));

    // Programmed thresholds, including a non-monotonic set.
    write_thr(3'd0, 8'h00);
    write_thr(3'd3, 8'hFF);
    send(8'h00, 1'b0); send(8'h90, 1'b0); send(8'h10, 1'b0); send(8'h40, 1'b0);
    send(8'hFF, 1'b1);
    idle(2);
    expect_vec("thr_prog", pack(1, 3, 1, 2, 7));

    // Reset while a vector is held and a new one is partly collected.
    @(negedge clk);
    m_ready = 1'b0;
    send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    idle(0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_m_valid", 32'(m_valid), 32'(0));
    check("async_codes", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(0));
    check("async_vec_cnt", 32'(vec_cnt), 32'(0));
    check("async_s_ready", 32'(s_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    send(8'h00, 1'b0); send(8'h40, 1'b0); send(8'h60, 1'b0); send(8'hC0, 1'b0);
    send(8'h20, 1'b1);
    idle(2);
    expect_vec("post_reset", pack(0, 2, 3, 6, 1));
    check("post_reset_only", 32'(got_q.size()), 32'(0));
    check("post_reset_cnt", 32'(vec_cnt), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
